// File: rtl/zrb_uart_rx.sv
// zrb_uart_rx: 8N1 UART receiver, LSB first, majority vote of three centre samples.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module zrb_uart_rx #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] c_smp_lo  = CW'(M - 1);
  localparam logic [CW-1:0] c_smp_mid = CW'(M);
  localparam logic [CW-1:0] c_smp_hi  = CW'(M + 1);
  localparam logic [CW-1:0] c_last    = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] c_one     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [2:0]    r_smp;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_busy;

  logic          w_rx_s;
  logic          w_capture;
  logic          w_maj_now;
  logic          w_maj_reg;
  logic [CW-1:0] w_cnt_inc;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_capture = baud_tick &&
                     ((r_cnt == c_smp_lo) || (r_cnt == c_smp_mid) || (r_cnt == c_smp_hi));

  // On the last sample tick the third vote is the live synchronised line value.
  assign w_maj_now = (r_smp[1] & r_smp[0]) | (r_smp[1] & w_rx_s) | (r_smp[0] & w_rx_s);
  assign w_maj_reg = (r_smp[2] & r_smp[1]) | (r_smp[2] & r_smp[0]) | (r_smp[1] & r_smp[0]);

  assign w_cnt_inc = (r_cnt == c_last) ? '0 : r_cnt + c_one;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_smp <= 3'b111;
    end else if (w_capture) begin
      r_smp <= {r_smp[1:0], w_rx_s};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (baud_tick) begin
        case (r_state)
          S_IDLE: begin
            if (!w_rx_s) begin
              r_state <= S_START;
              r_cnt   <= c_one;
              r_busy  <= 1'b1;
            end
          end

          S_START: begin
            r_cnt <= w_cnt_inc;
            if ((r_cnt == c_smp_hi) && w_maj_now) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else if (r_cnt == c_last) begin
              r_bit   <= 3'd0;
              r_state <= S_DATA;
            end
          end

          S_DATA: begin
            r_cnt <= w_cnt_inc;
            if (r_cnt == c_last) begin
              r_shift <= {w_maj_reg, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_state <= S_STOP;
              end
            end
          end

          // Deciding half a bit early leaves slack for a start edge right behind the stop bit.
          S_STOP: begin
            r_cnt <= w_cnt_inc;
            if (r_cnt == c_smp_hi) begin
              r_cnt <= '0;
              if (w_maj_now) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= S_WAIT_HIGH;
              end
            end
          end

          S_WAIT_HIGH: begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data        = r_data;
  assign data_valid  = r_valid;
  assign frame_error = r_ferr;
  assign busy        = r_busy;

endmodule

`default_nettype wire

// File: doc/zrb_uart_rx.md
Name: zrb_uart_rx

Overview:
- 8-bit UART receiver (8N1, LSB first).
- Oversamples the serial line using the rx-rate strobe from zrb_baud_generator (baud_clk_rx, 8 strobes per bit).
- Majority-votes three mid-bit samples and emits each received byte with a one-cycle valid pulse.
- Sits downstream of the serial line driven by zrb_uart_tx; its output pair feeds zrb_fifo data_in/wr_en directly.

Parameters:
- OVERSAMPLE, 8: baud_tick strobes per bit time. Must be even and >= 4.
- M (local), OVERSAMPLE/2: centre sample index.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- baud_tick  input  1  oversampling strobe; high for exactly one clk cycle, OVERSAMPLE times per bit.
- rx  input  1  asynchronous serial line; idle high.
- data  output  8  last correctly received byte.
- data_valid  output  1  one-clk pulse: data just updated.
- frame_error  output  1  one-clk pulse: stop bit sampled low.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
Reset values (async, while reset = 0):
- Outputs: data = 8'h00, data_valid = 0, frame_error = 0, busy = 0.
- Internal: sync flops = 1, state = IDLE, counters = 0.
Input synchronisation:
- rx passes through a 2-flop synchroniser to give rx_s.
- All decisions use rx_s. This adds 2 clk of latency.
Tick counting:
- Counter cnt runs 0..OVERSAMPLE-1 and advances only on baud_tick.
- On ticks where cnt is M-1, M or M+1, rx_s is captured into a 3-sample register.
- Bit value = majority of the 3 samples.
State machine (transitions happen only on baud_tick cycles):
- IDLE: if rx_s == 0, go to START with cnt <= 1 (the detect tick counts as tick 0).
- START: at cnt == M+1, if majority == 1 it is a false start: go to IDLE, no output. Otherwise continue. At cnt == OVERSAMPLE-1: cnt <= 0, bit index <= 0, go to DATA.
- DATA: at cnt == OVERSAMPLE-1, shift the majority into the shift register MSB (right shift, so the first bit lands in bit 0 after 8 bits), cnt <= 0, bit index += 1. After bit index 7, go to STOP.
- STOP: decision at cnt == M+1, half a bit early so back-to-back frames resynchronise.
  - Majority 1: data <= shift register, data_valid pulses, go to IDLE.
  - Majority 0: frame_error pulses, data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: on a tick with rx_s == 1, go to IDLE. A held-low line (break) produces exactly one frame_error, not repeated frames.
Output timing:
- data_valid and frame_error are registered. They are high in the clk cycle after the deciding tick, for exactly 1 clk, and never both high.
- data is stable from the data_valid cycle until the next data_valid.
- busy = (state != IDLE), registered with the state.
Latency:
- From the rx falling edge to data_valid: 2 clk (sync) + detect delay of up to 1 tick period + (9*OVERSAMPLE + M + 1) tick periods + 1 clk.
Boundary conditions:
- baud_tick held low: state frozen; no timeouts.
- A new start edge is accepted on the first tick after STOP returns to IDLE. No idle gap is required between frames.
- There is no back-pressure. A consumer must accept each pulse in its cycle (a full FIFO drops the byte; that is the consumer's responsibility).
- Reset asserted mid-frame: the frame is abandoned immediately, no pulse. After release the block waits in IDLE for a fresh falling edge; a line still low at release is treated as a start.

Test Plan:
All scenarios use OVERSAMPLE = 8, with baud_tick every 4 clk (1 bit = 32 clk).
1. Send frame 0x55 with a valid stop bit -> exactly one data_valid pulse; data = 0x55; frame_error stays 0; busy falls the same cycle as the pulse.
2. Hold rx low for 2 ticks, then high -> false start: busy high for about 4 ticks, then 0; no data_valid or frame_error; data unchanged.
3. Send 0xA3 with the stop bit low, then hold rx low for 20 bit times, then high, then send 0x3C -> one frame_error pulse; data stays 0x55 during the error; no pulses while low; then data_valid with data = 0x3C.
4. Send 0x0F with a 1-tick inverted glitch on the tick-3 sample of bits 2 and 5 -> data_valid with data = 0x0F (majority rejects the glitch).
5. Send 0x00, 0xFF, 0x81 back-to-back with no idle gap, and with tick period 4 clk ±3% jitter -> three data_valid pulses in order with the correct bytes; no frame_error.
6. Assert reset during bit 4 of 0x96, release, then send 0x96 -> all outputs go to reset values asynchronously with no pulse for the aborted frame; the next frame gives data_valid with data = 0x96.
